spi_byte_master: RTL and testbench

//  Byte-level SPI master directly downstream of the sensor-frame byte sequencer (byte/wren producer).

---
 rtl/spi_byte_master.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_byte_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master.sv
// spi_byte_master: byte-wide SPI mode-0 master fed through a one-byte holding
// register. Bytes are shifted MSB-first. Slave select is held low across
// back-to-back bytes. Each received MISO byte is returned with a valid pulse.
module spi_byte_master #(
  parameter int CLK_DIV  = 4,
  parameter int SS_IDLE  = 8,
  parameter int SS_SETUP = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       wren,
  output logic       di_req,
  output logic       write_ack,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ss_n,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int IDLE_W = $clog2(SS_IDLE + 1);
  localparam int SET_W  = $clog2(SS_SETUP + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(SS_IDLE - 1);
  localparam logic [SET_W-1:0]  SET_LAST   = SET_W'(SS_SETUP - 1);
  // Three cycles of guard keep a wren still held from the previous byte
  // from being taken a second time, even when the holding register drains
  // two cycles after the accept.
  localparam logic [1:0]        GUARD_INIT = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [1:0]         guard_q, guard_d;
  logic               write_ack_q, write_ack_d;
  logic [7:0]         tx_sh_q, tx_sh_d;
  logic [7:0]         rx_sh_q, rx_sh_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               ss_n_q, ss_n_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_s1_q, miso_s1_d;
  logic               miso_s2_q, miso_s2_d;
  logic               accept;
  logic               first_load;

  assign di_req    = !hold_full_q && (guard_q == 2'd0);
  assign accept    = wren && di_req;
  assign write_ack = write_ack_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_ss_n  = ss_n_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = !ss_n_q || hold_full_q;

  // Next-state, SCLK/MOSI generation, holding-register handshake
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    guard_d     = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    write_ack_d = 1'b0;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    set_cnt_d   = set_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ss_n_d      = ss_n_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    miso_s1_d   = spi_miso;
    miso_s2_d   = miso_s1_q;
    first_load  = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          ss_n_d = 1'b0;
          if (SS_SETUP == 1) begin
            first_load = 1'b1;
          end else begin
            state_d   = SETUP;
            set_cnt_d = SET_W'(1);
          end
        end
      end
      SETUP: begin
        if (set_cnt_q >= SET_LAST) begin
          first_load = 1'b1;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      SHIFT: begin
        if (!sclk_q) begin
          if (div_cnt_q == DIV_LAST) begin
            sclk_d    = 1'b1;
            div_cnt_d = '0;
            rx_sh_d   = {rx_sh_q[6:0], miso_s2_q};
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end else begin
          if (div_cnt_q == DIV_LAST) begin
            sclk_d    = 1'b0;
            div_cnt_d = '0;
            if (bit_cnt_q == 3'd7) begin
              rx_byte_d  = rx_sh_q;
              rx_valid_d = 1'b1;
              bit_cnt_d  = 3'd0;
              if (hold_full_q) begin
                // Reload straight from the holding register: the full low
                // phase that follows keeps the bytes contiguous.
                tx_sh_d     = hold_q;
                mosi_d      = hold_q[7];
                hold_full_d = 1'b0;
              end else begin
                state_d    = GAP;
                idle_cnt_d = '0;
                mosi_d     = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_sh_d   = {tx_sh_q[6:0], 1'b0};
              mosi_d    = tx_sh_q[6];
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
      end
      GAP: begin
        if (hold_full_q) begin
          // Slave is still selected, so the setup wait is skipped.
          state_d   = SETUP;
          set_cnt_d = SET_LAST;
        end else if (idle_cnt_q == IDLE_LAST) begin
          ss_n_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // First byte of a burst: the first SCLK rise follows one cycle later.
    if (first_load) begin
      state_d     = SHIFT;
      tx_sh_d     = hold_q;
      mosi_d      = hold_q[7];
      hold_full_d = 1'b0;
      sclk_d      = 1'b0;
      bit_cnt_d   = 3'd0;
      div_cnt_d   = DIV_LAST;
    end

    // Accept last: a shifter load in the same cycle has already taken the
    // old holding value.
    if (accept) begin
      hold_d      = byte_in;
      hold_full_d = 1'b1;
      write_ack_d = 1'b1;
      guard_d     = GUARD_INIT;
    end
  end

  // State and datapath registers; reset aborts any transfer immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      guard_q     <= 2'd0;
      write_ack_q <= 1'b0;
      tx_sh_q     <= 8'h00;
      rx_sh_q     <= 8'h00;
      div_cnt_q   <= '0;
      bit_cnt_q   <= 3'd0;
      set_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      guard_q     <= guard_d;
      write_ack_q <= write_ack_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      set_cnt_q   <= set_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_n_q      <= ss_n_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      miso_s1_q   <= miso_s1_d;
      miso_s2_q   <= miso_s2_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master (CLK_DIV=4, SS_IDLE=8, SS_SETUP=2).
`timescale 1ns/1ps
module tb_spi_byte_master;

  localparam int CLK_DIV  = 4;
  localparam int SS_IDLE  = 8;
  localparam int SS_SETUP = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       wren = 1'b0;
  logic       spi_miso = 1'b0;
  logic       di_req, write_ack, spi_sclk, spi_mosi, spi_ss_n, rx_valid, busy;
  logic [7:0] rx_byte;

  spi_byte_master #(.CLK_DIV(CLK_DIV), .SS_IDLE(SS_IDLE), .SS_SETUP(SS_SETUP)) dut (
    .clock(clock), .reset(reset), .byte_in(byte_in), .wren(wren),
    .di_req(di_req), .write_ack(write_ack), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss_n(spi_ss_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit sclk_prev = 1'b0;
  bit ss_prev   = 1'b1;
  int ack_cnt, rxv_cnt, rise_cnt, fall_cnt, ss_fall_cnt, ss_rise_cnt;
  int hi_len, hi_bad, period_bad, tx_bad;
  int last_rise_cyc, first_rise_cyc, ss_fall_cyc, ss_rise_cyc, last_fall_cyc, rxv_cyc;
  int cap_n, miso_idx, di_low, t_mosi, t_sclk;
  bit got;
  logic [7:0] last_rx, cap, last_tx, miso_pat;
  logic [7:0] exp_tx[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, observed at the falling edge; also runs the SPI slave model.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (write_ack) ack_cnt++;
    if (rx_valid) begin rxv_cnt++; last_rx = rx_byte; rxv_cyc = cyc; end
    if (!spi_ss_n && ss_prev) begin ss_fall_cnt++; ss_fall_cyc = cyc; end
    if (spi_ss_n && !ss_prev) begin ss_rise_cnt++; ss_rise_cyc = cyc; end
    if (spi_sclk && !sclk_prev) begin
      rise_cnt++;
      hi_len = 1;
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
      if (last_rise_cyc >= 0 && (cyc - last_rise_cyc) != 2*CLK_DIV) period_bad++;
      last_rise_cyc = cyc;
      cap = {cap[6:0], spi_mosi};
      cap_n++;
      if (cap_n == 8) begin
        last_tx = cap;
        cap_n = 0;
        if (exp_tx.size() == 0) tx_bad++;
        else begin
          if (exp_tx[0] !== cap) tx_bad++;
          void'(exp_tx.pop_front());
        end
      end
    end else if (spi_sclk) begin
      hi_len++;
    end else if (sclk_prev) begin
      fall_cnt++;
      last_fall_cyc = cyc;
      if (hi_len != CLK_DIV) hi_bad++;
      if (miso_idx >= 0) begin spi_miso = miso_pat[miso_idx]; miso_idx--; end
    end
    sclk_prev = spi_sclk;
    ss_prev   = spi_ss_n;
  endtask

  task automatic clr();
    ack_cnt = 0; rxv_cnt = 0; rise_cnt = 0; fall_cnt = 0; ss_fall_cnt = 0; ss_rise_cnt = 0;
    hi_bad = 0; period_bad = 0; tx_bad = 0; cap_n = 0;
    last_rise_cyc = -1; first_rise_cyc = -1; ss_fall_cyc = -1; ss_rise_cyc = -1;
    last_fall_cyc = -1; rxv_cyc = -1;
  endtask

  // Sequencer model: hold wren until write_ack is seen.
  task automatic push(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_in = b;
    wren = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (write_ack) ok = 1'b1;
    end
    wren = 1'b0;
    if (ok) exp_tx.push_back(b);
    check("push_ack", ok, 1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    for (int i = 0; i < 400 && rxv_cnt < n; i++) tick();
    check(tag, rxv_cnt >= n, 1);
  endtask

  task automatic wait_ss_rise(input string tag);
    for (int i = 0; i < 400 && ss_rise_cnt == 0; i++) tick();
    check(tag, ss_rise_cnt, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    miso_idx = -1; miso_pat = 8'h00; cap = 8'h00; last_tx = 8'h00; last_rx = 8'h00;
    repeat (3) tick();
    // reset state
    check("rst_di_req", di_req, 1);
    check("rst_write_ack", write_ack, 0);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ss_n", spi_ss_n, 1);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // 1: single byte A5
    clr();
    push(8'hA5);
    wait_rx(1, "t1_rx_wait");
    wait_ss_rise("t1_ss_rise");
    check("t1_ss_to_sclk", first_rise_cyc - ss_fall_cyc, SS_SETUP);
    check("t1_mosi_byte", last_tx, 8'hA5);
    check("t1_tx_order", tx_bad, 0);
    check("t1_rises", rise_cnt, 8);
    check("t1_falls", fall_cnt, 8);
    check("t1_high_width", hi_bad, 0);
    check("t1_period", period_bad, 0);
    check("t1_acks", ack_cnt, 1);
    check("t1_busy_end", busy, 0);

    // 2: 34-byte frame back to back
    clr();
    for (int i = 0; i < 34; i++) push(8'(i));
    wait_rx(34, "t2_rx_wait");
    wait_ss_rise("t2_ss_rise");
    check("t2_acks", ack_cnt, 34);
    check("t2_ss_falls", ss_fall_cnt, 1);
    check("t2_period", period_bad, 0);
    check("t2_high_width", hi_bad, 0);
    check("t2_rises", rise_cnt, 34*8);
    check("t2_tx_bytes", tx_bad, 0);
    check("t2_last_byte", last_tx, 8'h21);
    check("t2_ss_idle", ss_rise_cyc - last_fall_cyc, SS_IDLE);
    check("t2_rx_count", rxv_cnt, 34);

    // 3: MISO returns 3C while FF is sent
    clr();
    miso_pat = 8'h3C;
    spi_miso = miso_pat[7];
    miso_idx = 6;
    push(8'hFF);
    wait_rx(1, "t3_rx_wait");
    wait_ss_rise("t3_ss_rise");
    check("t3_rx_at_valid", last_rx, 8'h3C);
    check("t3_rx_byte", rx_byte, 8'h3C);
    check("t3_valid_on_8th_fall", rxv_cyc, last_fall_cyc);
    check("t3_fall_count", fall_cnt, 8);
    check("t3_rx_count", rxv_cnt, 1);
    check("t3_mosi_byte", last_tx, 8'hFF);
    spi_miso = 1'b0;
    miso_idx = -1;

    // 4: wren held high three cycles past the accept
    clr();
    byte_in = 8'h5A;
    wren = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = write_ack; end
    check("t4_ack", got, 1);
    exp_tx.push_back(8'h5A);
    di_low = (di_req == 1'b0) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (di_req == 1'b0 && di_low == i + 1) di_low++;
    end
    wren = 1'b0;
    check("t4_di_req_guard", di_low >= 2, 1);
    wait_rx(1, "t4_rx_wait");
    wait_ss_rise("t4_ss_rise");
    check("t4_single_ack", ack_cnt, 1);
    check("t4_mosi_byte", last_tx, 8'h5A);
    check("t4_tx_order", tx_bad, 0);
    check("t4_rx_count", rxv_cnt, 1);

    // 5: second byte 5 idle cycles after the first ends
    clr();
    push(8'h81);
    wait_rx(1, "t5_rx1_wait");
    repeat (5) tick();
    last_rise_cyc = -1;
    push(8'hC3);
    got = 1'b0; t_mosi = -1;
    for (int i = 0; i < 30 && !got; i++) begin tick(); if (spi_mosi) begin got = 1'b1; t_mosi = cyc; end end
    check("t5_load_seen", got, 1);
    got = 1'b0; t_sclk = -1;
    for (int i = 0; i < 30 && !got; i++) begin tick(); if (spi_sclk) begin got = 1'b1; t_sclk = cyc; end end
    check("t5_rise_seen", got, 1);
    check("t5_rise_after_load", t_sclk - t_mosi, 1);
    wait_rx(2, "t5_rx2_wait");
    wait_ss_rise("t5_ss_rise");
    check("t5_ss_falls", ss_fall_cnt, 1);
    check("t5_mosi_byte", last_tx, 8'hC3);
    check("t5_tx_order", tx_bad, 0);
    check("t5_acks", ack_cnt, 2);

    // 6: reset at the 4th SCLK high
    clr();
    push(8'h96);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin tick(); if (rise_cnt == 4) got = 1'b1; end
    check("t6_reach_4th_high", got, 1);
    check("t6_sclk_before", spi_sclk, 1);
    reset = 1'b1;
    #1;
    check("t6_ss_async", spi_ss_n, 1);
    check("t6_sclk_async", spi_sclk, 0);
    repeat (3) tick();
    check("t6_no_rx_valid", rxv_cnt, 0);
    check("t6_one_ack", ack_cnt, 1);
    reset = 1'b0;
    tick();
    check("t6_di_req_after", di_req, 1);
    check("t6_busy_after", busy, 0);
    check("t6_rx_byte_after", rx_byte, 8'h00);
    clr();
    exp_tx.delete();
    cap = 8'h00;
    miso_pat = 8'h99;
    spi_miso = miso_pat[7];
    miso_idx = 6;
    push(8'h69);
    wait_rx(1, "t6_rx_wait");
    wait_ss_rise("t6_ss_rise");
    check("t6_mosi_byte", last_tx, 8'h69);
    check("t6_tx_order", tx_bad, 0);
    check("t6_rises", rise_cnt, 8);
    check("t6_rx_byte", last_rx, 8'h99);
    check("t6_high_width", hi_bad, 0);
    check("t6_acks", ack_cnt, 1);
    spi_miso = 1'b0;
    miso_idx = -1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
